// File: rtl/lsu_pkg.sv
// Package: lsu_pkg
// Shared encodings for the load/store unit: access sizes, fault causes,
// the sequencer state type and the store lane-replication helper.
package lsu_pkg;

    // Access size encodings as seen on req_size / mem_size
    localparam logic [1:0] SIZE_BYTE    = 2'b00;
    localparam logic [1:0] SIZE_HALF    = 2'b01;
    localparam logic [1:0] SIZE_WORD    = 2'b10;
    localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

    // Fault cause encodings reported on resp_cause
    localparam logic [1:0] CAUSE_NONE       = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGNED = 2'b01;
    localparam logic [1:0] CAUSE_RANGE      = 2'b10;
    localparam logic [1:0] CAUSE_ILLEGAL    = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        DATA  = 2'b10,
        RESP  = 2'b11
    } lsu_state_t;

    // Replicate right-aligned store data across all byte lanes so the RAM
    // can pick whichever lane its byte enables select.
    function automatic logic [31:0] lane_replicate(input logic [1:0] size,
                                                   input logic [31:0] wdata);
        logic [31:0] lanes;
        case (size)
            SIZE_BYTE: lanes = {4{wdata[7:0]}};
            SIZE_HALF: lanes = {2{wdata[15:0]}};
            default:   lanes = wdata;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Module: lsu_align
// Combinational request checker: size/range/alignment fault detection with
// priority illegal-size > out-of-range > misaligned, forced alignment of the
// RAM byte address, and store lane replication.
// Optional feature macro: MISALIGN_TRAP_EN
//   defined   -> misaligned half/word requests fault with CAUSE_MISALIGNED
//   undefined -> misaligned requests have their low address bits cleared
// Ports:
//   addr         in  32             request byte address
//   size         in  2              request access size
//   wdata        in  32             right-aligned store data
//   fault        out 1              request must not touch memory
//   cause        out 2              fault cause (CAUSE_NONE when no fault)
//   addr_aligned out MEM_ADDR_SIZE  RAM byte address after forced alignment
//   lane_data    out 32             lane-replicated store data
module lsu_align
    import lsu_pkg::*;
#(
    parameter int MEM_ADDR_SIZE = 12
) (
    input  logic [31:0]              addr,
    input  logic [1:0]               size,
    input  logic [31:0]              wdata,
    output logic                     fault,
    output logic [1:0]               cause,
    output logic [MEM_ADDR_SIZE-1:0] addr_aligned,
    output logic [31:0]              lane_data
);

    logic range_bad_s;
    logic misaligned_s;

    // Raw range and natural-alignment conditions
    always_comb begin
        range_bad_s = ((addr >> MEM_ADDR_SIZE) != 32'd0);
        case (size)
            SIZE_HALF: misaligned_s = addr[0];
            SIZE_WORD: misaligned_s = (addr[1:0] != 2'b00);
            default:   misaligned_s = 1'b0;
        endcase
    end

    // Fault cause in priority order
    always_comb begin
        cause = CAUSE_NONE;
        if (size == SIZE_ILLEGAL) begin
            cause = CAUSE_ILLEGAL;
        end else if (range_bad_s) begin
            cause = CAUSE_RANGE;
`ifdef MISALIGN_TRAP_EN
        end else if (misaligned_s) begin
            cause = CAUSE_MISALIGNED;
`endif
        end else begin
            cause = CAUSE_NONE;
        end
        fault = (cause != CAUSE_NONE);
    end

    // RAM byte address; without trapping, misaligned accesses are pulled down
    // to the enclosing naturally aligned unit
    always_comb begin
        addr_aligned = addr[MEM_ADDR_SIZE-1:0];
`ifndef MISALIGN_TRAP_EN
        if (misaligned_s) begin
            if (size == SIZE_WORD) begin
                addr_aligned[1:0] = 2'b00;
            end else begin
                addr_aligned[0] = 1'b0;
            end
        end else begin
            addr_aligned = addr[MEM_ADDR_SIZE-1:0];
        end
`endif
    end

    assign lane_data = lane_replicate(size, wdata);

endmodule

// File: rtl/load_store_unit.sv
// Module: load_store_unit
// Memory-stage load/store sequencer between execute and data RAM port B.
// One request per valid/ready handshake, one response beat per request.
// Sequence: IDLE -> ISSUE -> DATA -> RESP for loads, IDLE -> ISSUE -> RESP
// for stores, IDLE -> RESP for faulted requests.
// Optional feature macro: MISALIGN_TRAP_EN (see lsu_align).
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   req_valid/req_ready            request handshake
//   req_write/addr/wdata/size/unsigned/rd   request fields
//   resp_valid/resp_ready          response handshake
//   resp_data/rd/fault/cause       response fields
//   mem_en_write/mem_en_read       one-cycle RAM strobes (ISSUE only)
//   mem_addr/din/size/unsigned     RAM access fields, held through RESP
//   mem_dout                       RAM extended read data
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int NUM_WORDS     = 1024,
    parameter int MEM_ADDR_SIZE = $clog2(NUM_WORDS * 4),
    parameter int RD_WIDTH      = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [31:0]              req_addr,
    input  logic [31:0]              req_wdata,
    input  logic [1:0]               req_size,
    input  logic                     req_unsigned,
    input  logic [RD_WIDTH-1:0]      req_rd,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [31:0]              resp_data,
    output logic [RD_WIDTH-1:0]      resp_rd,
    output logic                     resp_fault,
    output logic [1:0]               resp_cause,
    output logic                     mem_en_write,
    output logic                     mem_en_read,
    output logic [MEM_ADDR_SIZE-1:0] mem_addr,
    output logic [31:0]              mem_din,
    output logic [1:0]               mem_size,
    output logic                     mem_unsigned,
    input  logic [31:0]              mem_dout
);

    lsu_state_t               state_r;
    lsu_state_t               state_next_s;
    logic                     write_r;
    logic                     accept_s;
    logic                     chk_fault_s;
    logic [1:0]               chk_cause_s;
    logic [MEM_ADDR_SIZE-1:0] chk_addr_s;
    logic [31:0]              chk_din_s;

    lsu_align #(
        .MEM_ADDR_SIZE (MEM_ADDR_SIZE)
    ) u_align (
        .addr         (req_addr),
        .size         (req_size),
        .wdata        (req_wdata),
        .fault        (chk_fault_s),
        .cause        (chk_cause_s),
        .addr_aligned (chk_addr_s),
        .lane_data    (chk_din_s)
    );

    // Ready is gated by rst directly so nothing is accepted during reset
    assign req_ready = (state_r == IDLE) && !rst;
    assign accept_s  = req_valid && req_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_next_s = chk_fault_s ? RESP : ISSUE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ISSUE:   state_next_s = write_r ? RESP : DATA;
            DATA:    state_next_s = RESP;
            RESP: begin
                if (resp_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RESP;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Registered RAM and response outputs. Strobes are set on the accept
    // edge so they are high for exactly the ISSUE cycle; the response is
    // raised on the edge that enters RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            write_r      <= 1'b0;
            mem_en_write <= 1'b0;
            mem_en_read  <= 1'b0;
            mem_addr     <= '0;
            mem_din      <= 32'd0;
            mem_size     <= 2'b00;
            mem_unsigned <= 1'b0;
            resp_valid   <= 1'b0;
            resp_data    <= 32'd0;
            resp_rd      <= '0;
            resp_fault   <= 1'b0;
            resp_cause   <= CAUSE_NONE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        write_r      <= req_write;
                        mem_addr     <= chk_addr_s;
                        mem_din      <= chk_din_s;
                        mem_size     <= req_size;
                        mem_unsigned <= req_unsigned;
                        mem_en_write <= req_write && !chk_fault_s;
                        mem_en_read  <= !req_write && !chk_fault_s;
                        resp_rd      <= req_rd;
                        resp_data    <= 32'd0;
                        resp_fault   <= chk_fault_s;
                        resp_cause   <= chk_cause_s;
                        resp_valid   <= chk_fault_s;
                    end else begin
                        resp_valid <= 1'b0;
                    end
                end
                ISSUE: begin
                    mem_en_write <= 1'b0;
                    mem_en_read  <= 1'b0;
                    resp_valid   <= write_r;
                end
                DATA: begin
                    resp_data  <= mem_dout;
                    resp_valid <= 1'b1;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                    end else begin
                        resp_valid <= 1'b1;
                    end
                end
                default: begin
                    mem_en_write <= 1'b0;
                    mem_en_read  <= 1'b0;
                    resp_valid   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int NW = 1024;
    localparam int AW = 12;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write, req_unsigned;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic [4:0]  req_rd;
    logic        resp_valid, resp_ready, resp_fault;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic [1:0]  resp_cause;
    logic        mem_en_write, mem_en_read, mem_unsigned;
    logic [AW-1:0] mem_addr;
    logic [31:0] mem_din, mem_dout;
    logic [1:0]  mem_size;

    always #5 clk = ~clk;

    load_store_unit #(.NUM_WORDS(NW), .MEM_ADDR_SIZE(AW), .RD_WIDTH(5)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_rd(req_rd),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_rd(resp_rd), .resp_fault(resp_fault), .resp_cause(resp_cause),
        .mem_en_write(mem_en_write), .mem_en_read(mem_en_read), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_size(mem_size), .mem_unsigned(mem_unsigned),
        .mem_dout(mem_dout)
    );

    // ---- RAM port B model: byte-enabled write, registered word read, extraction
    // ---- driven combinationally from the held address/size/extension
    logic [31:0] ram [0:NW-1];
    logic [31:0] ram_q;
    logic [3:0]  be_s;
    logic [31:0] sh_s;

    always_comb begin
        case (mem_size)
            2'b00:   be_s = 4'b0001 << mem_addr[1:0];
            2'b01:   be_s = 4'b0011 << mem_addr[1:0];
            default: be_s = 4'b1111;
        endcase
    end

    always @(posedge clk) begin
        if (mem_en_write)
            for (int k = 0; k < 4; k++)
                if (be_s[k]) ram[mem_addr[AW-1:2]][k*8 +: 8] <= mem_din[k*8 +: 8];
        if (mem_en_read) ram_q <= ram[mem_addr[AW-1:2]];
    end

    always_comb begin
        sh_s = ram_q >> (8 * mem_addr[1:0]);
        case (mem_size)
            2'b00:   mem_dout = mem_unsigned ? {24'd0, sh_s[7:0]} : {{24{sh_s[7]}}, sh_s[7:0]};
            2'b01:   mem_dout = mem_unsigned ? {16'd0, sh_s[15:0]} : {{16{sh_s[15]}}, sh_s[15:0]};
            default: mem_dout = ram_q;
        endcase
    end

    // ---- reference model: flat byte memory
    logic [7:0] gmem [0:4*NW-1];
    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic predict(input logic w, input logic [31:0] a, input logic [1:0] sz,
                           input logic u, output logic [1:0] cause,
                           output logic [31:0] ea, output logic [31:0] data);
        int nb;
        cause = 2'b00; ea = a; data = 32'd0; nb = 1 << sz;
        if (sz == 2'b11) cause = 2'b11;
        else if (a >= 32'h0000_1000) cause = 2'b10;
        else if ((a % nb) != 0) begin
`ifdef MISALIGN_TRAP_EN
            cause = 2'b01;
`else
            ea = a - (a % nb);
`endif
        end
        if (cause == 2'b00 && !w) begin
            for (int i = 0; i < nb; i++) data = data | (32'(gmem[ea + i]) << (8 * i));
            if (!u && nb < 4 && data[8*nb-1]) data = data | (32'hFFFF_FFFF << (8 * nb));
        end
    endtask

    task automatic commit_store(input logic [31:0] ea, input logic [1:0] sz, input logic [31:0] d);
        for (int i = 0; i < (1 << sz); i++) gmem[ea + i] = 8'(d >> (8 * i));
    endtask

    function automatic logic [31:0] replicate(input logic [1:0] sz, input logic [31:0] d);
        if (sz == 2'b00) return {24'd0, d[7:0]} * 32'h0101_0101;
        else if (sz == 2'b01) return {16'd0, d[15:0]} * 32'h0001_0001;
        else return d;
    endfunction

    task automatic drive_accept(input logic w, input logic [31:0] a, input logic [31:0] d,
                                input logic [1:0] sz, input logic u, input logic [4:0] rd);
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        req_size = sz; req_unsigned = u; req_rd = rd;
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic run_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [1:0] sz, input logic u, input logic [4:0] rd,
                           input int stall);
        logic [1:0]  cause;
        logic [31:0] ea, edata, din_cap, addr_cap, size_cap, snap;
        int lat, rdp, wrp, elat;
        predict(w, a, sz, u, cause, ea, edata);
        elat = (cause != 2'b00) ? 1 : (w ? 2 : 3);
        drive_accept(w, a, d, sz, u, rd);
        // garbage on the request side must be ignored while not ready
        req_valid = 1'($urandom); req_write = 1'($urandom); req_addr = $urandom;
        lat = 0; rdp = 0; wrp = 0; din_cap = 0; addr_cap = 0; size_cap = 0;
        while (lat < 8) begin
            @(negedge clk);
            lat++;
            if (mem_en_read)  begin rdp++; addr_cap = 32'(mem_addr); end
            if (mem_en_write) begin wrp++; addr_cap = 32'(mem_addr); din_cap = mem_din; size_cap = 32'(mem_size); end
            if (resp_valid) break;
        end
        req_valid = 1'b0;
        chk("latency", lat, elat);
        chk("read_pulses",  rdp, (cause == 2'b00 && !w) ? 1 : 0);
        chk("write_pulses", wrp, (cause == 2'b00 &&  w) ? 1 : 0);
        if (cause == 2'b00) chk("mem_addr", addr_cap, ea);
        if (cause == 2'b00 && w) begin
            chk("mem_din", din_cap, replicate(sz, d));
            chk("mem_size", size_cap, 32'(sz));
        end
        snap = resp_data;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk("hold_valid", 32'(resp_valid), 32'd1);
            chk("hold_data", resp_data, snap);
            chk("hold_req_ready", 32'(req_ready), 32'd0);
        end
        chk("resp_data",  resp_data, edata);
        chk("resp_fault", 32'(resp_fault), (cause != 2'b00) ? 32'd1 : 32'd0);
        chk("resp_cause", 32'(resp_cause), 32'(cause));
        chk("resp_rd",    32'(resp_rd), 32'(rd));
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        if (w && cause == 2'b00) commit_store(ea, sz, d);
        @(negedge clk);
        chk("resp_dropped", 32'(resp_valid), 32'd0);
        chk("ready_after",  32'(req_ready), 32'd1);
    endtask

    task automatic rst_mid(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [1:0] sz, input int at_cycle);
        logic [1:0]  cause;
        logic [31:0] ea, edata;
        predict(w, a, sz, 1'b0, cause, ea, edata);
        drive_accept(w, a, d, sz, 1'b0, 5'd1);
        req_valid = 1'b0;
        for (int c = 0; c < at_cycle; c++) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_mem_en", {30'd0, mem_en_read, mem_en_write}, 32'd0);
        chk("rst_mem_fields", {19'd0, mem_unsigned, mem_addr} | mem_din | 32'(mem_size), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        if (w && cause == 2'b00 && at_cycle >= 1) commit_store(ea, sz, d);
    endtask

    initial begin
        for (int i = 0; i < NW; i++) ram[i] = 32'd0;
        for (int i = 0; i < 4 * NW; i++) gmem[i] = 8'd0;
        ram_q = 32'd0;
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        req_size = 2'b00; req_unsigned = 1'b0; req_rd = 5'd0; resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        chk("reset_resp", {29'd0, resp_valid, resp_fault, 1'b0} | 32'(resp_cause) | 32'(resp_rd), 32'd0);
        chk("reset_resp_data", resp_data, 32'd0);
        chk("reset_mem", {28'd0, mem_en_read, mem_en_write, mem_size} | 32'(mem_addr) | mem_din, 32'd0);
        rst = 1'b0;

        run_req(1'b1, 32'h010, 32'hCAFE_BABE, SIZE_WORD, 1'b0, 5'd1, 0);
        run_req(1'b0, 32'h010, 32'd0,         SIZE_WORD, 1'b0, 5'd2, 0);
        run_req(1'b1, 32'h013, 32'h0000_0080, SIZE_BYTE, 1'b0, 5'd3, 0);
        run_req(1'b0, 32'h013, 32'd0,         SIZE_BYTE, 1'b0, 5'd4, 0);
        run_req(1'b0, 32'h013, 32'd0,         SIZE_BYTE, 1'b1, 5'd5, 0);
        run_req(1'b0, 32'h011, 32'd0,         SIZE_HALF, 1'b0, 5'd6, 0);
        run_req(1'b0, 32'h1000, 32'd0,        SIZE_WORD, 1'b0, 5'd7, 0);
        run_req(1'b0, 32'h1001, 32'd0,        SIZE_ILLEGAL, 1'b0, 5'd8, 0);
        run_req(1'b1, 32'h2003, 32'h1234,     SIZE_WORD, 1'b0, 5'd9, 0);
        run_req(1'b0, 32'h010, 32'd0,         SIZE_WORD, 1'b0, 5'd10, 5);
        rst_mid(1'b0, 32'h010, 32'd0,         SIZE_WORD, 2);
        rst_mid(1'b1, 32'h040, 32'h1234_5678, SIZE_WORD, 1);
        run_req(1'b0, 32'h040, 32'd0,         SIZE_WORD, 1'b0, 5'd11, 0);

        for (int n = 0; n < 300; n++) begin
            logic [1:0]  sz;
            logic [31:0] a;
            int r;
            r  = int'($urandom % 8);
            sz = (r == 7) ? SIZE_ILLEGAL : 2'(r % 3);
            a  = ($urandom % 12 == 0) ? $urandom : ($urandom % 256);
            run_req(1'($urandom), a, $urandom, sz, 1'($urandom), 5'($urandom), int'($urandom % 4));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
